// File: rtl/fir_mac_accumulator.sv
// fir_mac_accumulator: per-beat LANES-way I/Q sum, GROUPS-beat accumulation, scaled valid/ready output.
// Define FIR_MAC_ACC_SAT_EN for round-half-up plus saturation (sat_hit); default truncates and wraps.
module fir_mac_accumulator #(
    parameter int P_WIDTH   = 52,
    parameter int LANES     = 5,
    parameter int GROUPS    = 3,
    parameter int ACC_WIDTH = 56,
    parameter int OUT_WIDTH = 24,
    parameter int OUT_SHIFT = 26
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [P_WIDTH*LANES-1:0]   prod_i,
    input  logic [P_WIDTH*LANES-1:0]   prod_q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH-1:0]       out_i,
    output logic [OUT_WIDTH-1:0]       out_q,
    output logic                       err_frame,
    output logic                       overrun,
    output logic                       sat_hit
);
    localparam int CW = GROUPS > 1 ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(GROUPS - 1);

    logic signed [ACC_WIDTH-1:0] w_sum_i, w_sum_q, r_s1_i, r_s1_q;
    logic signed [ACC_WIDTH-1:0] r_acc_i, r_acc_q, w_new_i, w_new_q;
    logic                        r_s1_valid, r_s1_last, r_res_valid;
    logic [CW-1:0]               r_cnt;
    logic [OUT_WIDTH-1:0]        w_res_i, w_res_q, r_res_i, r_res_q;
    logic                        w_sat;

    always_comb begin
        w_sum_i = '0;
        w_sum_q = '0;
        for (int k = 0; k < LANES; k++) begin
            w_sum_i = w_sum_i + {{(ACC_WIDTH-P_WIDTH){prod_i[k*P_WIDTH+P_WIDTH-1]}}, prod_i[k*P_WIDTH +: P_WIDTH]};
            w_sum_q = w_sum_q + {{(ACC_WIDTH-P_WIDTH){prod_q[k*P_WIDTH+P_WIDTH-1]}}, prod_q[k*P_WIDTH +: P_WIDTH]};
        end
    end

    assign w_new_i = r_acc_i + r_s1_i;
    assign w_new_q = r_acc_q + r_s1_q;

`ifdef FIR_MAC_ACC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] RND  = ACC_WIDTH'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] MINV = -MAXV - 1;

    // Returns {clamped, value}.
    function automatic logic [OUT_WIDTH:0] scale(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] s;
        s = (a + RND) >>> OUT_SHIFT;
        return s > MAXV ? {1'b1, MAXV[OUT_WIDTH-1:0]} :
               s < MINV ? {1'b1, MINV[OUT_WIDTH-1:0]} : {1'b0, s[OUT_WIDTH-1:0]};
    endfunction

    logic w_sat_i, w_sat_q;
    assign {w_sat_i, w_res_i} = scale(w_new_i);
    assign {w_sat_q, w_res_q} = scale(w_new_q);
    assign w_sat = w_sat_i | w_sat_q;
`else
    function automatic logic [OUT_WIDTH-1:0] scale(input logic signed [ACC_WIDTH-1:0] a);
        return OUT_WIDTH'(a >>> OUT_SHIFT);
    endfunction

    assign w_res_i = scale(w_new_i);
    assign w_res_q = scale(w_new_q);
    assign w_sat   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_i      <= '0;
            r_s1_q      <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_i     <= '0;
            r_res_q     <= '0;
            out_valid   <= 1'b0;
            out_i       <= '0;
            out_q       <= '0;
            err_frame   <= 1'b0;
            overrun     <= 1'b0;
            sat_hit     <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_last  <= in_valid && in_last;
            if (in_valid) begin
                r_s1_i <= w_sum_i;
                r_s1_q <= w_sum_q;
                if (in_last) begin
                    err_frame <= err_frame | (r_cnt != LAST_CNT);
                    r_cnt     <= '0;
                end else if (r_cnt == LAST_CNT) begin
                    err_frame <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            r_res_valid <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                r_acc_i <= r_s1_last ? '0 : w_new_i;
                r_acc_q <= r_s1_last ? '0 : w_new_q;
                if (r_s1_last) begin
                    r_res_i <= w_res_i;
                    r_res_q <= w_res_q;
                    sat_hit <= sat_hit | w_sat;
                end
            end
            // A pending result is dropped only when the held one is not being consumed.
            if (r_res_valid && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_i     <= r_res_i;
                out_q     <= r_res_q;
            end else if (r_res_valid) begin
                overrun <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_accumulator.sv
// tb_fir_mac_accumulator: randomized and directed checks of fir_mac_accumulator against a frame-level model.
// Expected values follow FIR_MAC_ACC_SAT_EN when it is defined for the build.
module tb_fir_mac_accumulator;
    localparam int PW = 52, L = 5, G = 3, AW = 56, OW = 24, SH = 26;
    localparam longint OMAX = (longint'(1) <<< (OW - 1)) - 1;
    localparam longint OMIN = -(longint'(1) <<< (OW - 1));

    logic clk = 1'b0;
    logic reset, in_valid, in_last, out_ready;
    logic [PW*L-1:0] prod_i, prod_q;
    logic out_valid, err_frame, overrun, sat_hit;
    logic [OW-1:0] out_i, out_q;

    int checks = 0, failures = 0;
    longint acc_i, acc_q;
    int m_cnt;
    bit m_err, m_ovr, m_sat, mon_en;
    logic [OW-1:0] exp_i, exp_q, mon_i, mon_q;
    logic [OW-1:0] qi[$], qq[$];

    fir_mac_accumulator #(.P_WIDTH(PW), .LANES(L), .GROUPS(G), .ACC_WIDTH(AW),
                          .OUT_WIDTH(OW), .OUT_SHIFT(SH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .prod_i(prod_i), .prod_q(prod_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q), .err_frame(err_frame), .overrun(overrun), .sat_hit(sat_hit)
    );

    always #5 clk = ~clk;

    function automatic logic [PW*L-1:0] fill(input longint v);
        logic [PW*L-1:0] r;
        for (int k = 0; k < L; k++) r[k*PW +: PW] = v[PW-1:0];
        return r;
    endfunction

    function automatic logic [OW-1:0] tb_scale(input longint a, output bit clamp);
        longint s;
`ifdef FIR_MAC_ACC_SAT_EN
        s = (a + (longint'(1) <<< (SH - 1))) >>> SH;
        clamp = (s > OMAX) || (s < OMIN);
        if (s > OMAX) s = OMAX;
        if (s < OMIN) s = OMIN;
`else
        s = a >>> SH;
        clamp = 1'b0;
`endif
        return s[OW-1:0];
    endfunction

    task automatic do_reset();
        reset = 1; in_valid = 0; in_last = 0; out_ready = 1;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        acc_i = 0; acc_q = 0; m_cnt = 0; m_err = 0; m_ovr = 0; m_sat = 0;
    endtask

    task automatic beat(input logic [PW*L-1:0] pi, input logic [PW*L-1:0] pq, input logic last);
        bit c_i, c_q;
        longint lane;
        prod_i = pi; prod_q = pq; in_last = last; in_valid = 1;
        for (int k = 0; k < L; k++) begin
            lane = $signed(pi[k*PW +: PW]); acc_i += lane;
            lane = $signed(pq[k*PW +: PW]); acc_q += lane;
        end
        if (last) begin
            if (m_cnt != G - 1) m_err = 1;
            m_cnt = 0;
            exp_i = tb_scale(acc_i, c_i);
            exp_q = tb_scale(acc_q, c_q);
            m_sat = m_sat | c_i | c_q;
            acc_i = 0; acc_q = 0;
            if (mon_en) begin qi.push_back(exp_i); qq.push_back(exp_q); end
        end else if (m_cnt == G - 1) m_err = 1;
        else m_cnt++;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
    endtask

    task automatic wait_result(input string name);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_early out_valid=%b expected 0", name, out_valid); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_valid out_valid=%b expected 1", name, out_valid); end
        checks++;
        if (out_i !== exp_i) begin failures++; $display("FAIL %s_i out_i=%0d expected %0d", name, $signed(out_i), $signed(exp_i)); end
        checks++;
        if (out_q !== exp_q) begin failures++; $display("FAIL %s_q out_q=%0d expected %0d", name, $signed(out_q), $signed(exp_q)); end
        checks++;
        if ({err_frame, overrun, sat_hit} !== {m_err, m_ovr, m_sat})
            begin failures++; $display("FAIL %s_flags err/ovr/sat=%b%b%b expected %b%b%b", name, err_frame, overrun, sat_hit, m_err, m_ovr, m_sat); end
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            checks++;
            if (qi.size() == 0) begin
                failures++; $display("FAIL rand_extra unexpected result out_i=%0d", $signed(out_i));
            end else begin
                mon_i = qi.pop_front(); mon_q = qq.pop_front();
                if ({out_i, out_q} !== {mon_i, mon_q})
                    begin failures++; $display("FAIL rand_result got %0d/%0d expected %0d/%0d", $signed(out_i), $signed(out_q), $signed(mon_i), $signed(mon_q)); end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, out_i, out_q, err_frame, overrun, sat_hit} !== '0)
            begin failures++; $display("FAIL reset_state valid=%b i=%0d q=%0d flags=%b%b%b expected all 0", out_valid, out_i, out_q, err_frame, overrun, sat_hit); end
    endtask

    task automatic test_nominal();
        do_reset();
        for (int b = 0; b < G; b++) beat(fill(longint'(1) <<< 26), fill(-(longint'(1) <<< 26)), b == G - 1);
        wait_result("nominal");
    endtask

    task automatic test_rounding();
        logic [PW*L-1:0] p;
        do_reset();
        p = '0;
        p[PW-1:0] = PW'(1) << 25;
        beat(p, '0, 0); beat('0, '0, 0); beat('0, '0, 1);
        wait_result("rounding");
    endtask

    task automatic test_short_frame();
        do_reset();
        beat(fill(longint'(1) <<< 26), '0, 0); beat(fill(longint'(1) <<< 26), '0, 1);
        wait_result("short");
        for (int b = 0; b < G; b++) beat(fill(longint'(1) <<< 26), '0, b == G - 1);
        wait_result("after_short");
    endtask

    task automatic test_long_frame();
        do_reset();
        for (int b = 0; b < G + 1; b++) beat(fill(longint'(1) <<< 26), fill(longint'(3) <<< 25), b == G);
        wait_result("long");
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] held;
        do_reset();
        out_ready = 0;
        for (int b = 0; b < G; b++) beat(fill(longint'(1) <<< 26), '0, b == G - 1);
        wait_result("bp_first");
        held = exp_i;
        for (int b = 0; b < G; b++) beat(fill(longint'(1) <<< 27), '0, b == G - 1);
        m_ovr = 1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_i !== held)
            begin failures++; $display("FAIL bp_hold valid=%b out_i=%0d expected 1/%0d", out_valid, $signed(out_i), $signed(held)); end
        checks++;
        if (overrun !== m_ovr) begin failures++; $display("FAIL bp_overrun overrun=%b expected %b", overrun, m_ovr); end
        out_ready = 1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_consume out_valid=%b expected 0", out_valid); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_second out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int b = 0; b < G; b++) beat(fill(longint'(1) <<< 50), '0, b == G - 1);
        wait_result("saturation");
    endtask

    task automatic test_reset_midframe();
        do_reset();
        beat(fill(longint'(1) <<< 26), '0, 0); beat(fill(longint'(1) <<< 26), '0, 0);
        do_reset();
        for (int b = 0; b < G; b++) beat(fill(longint'(1) <<< 26), '0, b == G - 1);
        wait_result("reset_mid");
    endtask

    task automatic test_back_to_back();
        logic [PW*L-1:0] pi, pq;
        longint v;
        do_reset();
        mon_en = 1;
        for (int f = 0; f < 12; f++) begin
            for (int b = 0; b < G; b++) begin
                for (int k = 0; k < L; k++) begin
                    v = $signed({$urandom, $urandom}) >>> (f < 6 ? 12 : 24);
                    pi[k*PW +: PW] = v[PW-1:0];
                    v = $signed({$urandom, $urandom}) >>> (f < 6 ? 12 : 24);
                    pq[k*PW +: PW] = v[PW-1:0];
                end
                beat(pi, pq, b == G - 1);
                if (f >= 8) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
        repeat (4) @(posedge clk);
        #1;
        mon_en = 0;
        checks++;
        if (qi.size() != 0) begin failures++; $display("FAIL rand_missing %0d results not produced, expected 0", qi.size()); end
        checks++;
        if ({err_frame, overrun, sat_hit} !== {m_err, m_ovr, m_sat})
            begin failures++; $display("FAIL rand_flags err/ovr/sat=%b%b%b expected %b%b%b", err_frame, overrun, sat_hit, m_err, m_ovr, m_sat); end
    endtask

    initial begin
        reset = 1; in_valid = 0; in_last = 0; prod_i = '0; prod_q = '0; out_ready = 1; mon_en = 0;
        test_reset();
        test_nominal();
        test_rounding();
        test_short_frame();
        test_long_frame();
        test_backpressure();
        test_saturation();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
